// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
//
// Multi-channel leaky integrate-and-fire block. NUM_NEURONS independent
// membrane potentials are updated once per tick. A tick comes from the
// internal prescaler wrap, from a rising edge on the manual step input, or
// from both in the same cycle, which still counts as one tick.
//
// Each neuron, on a tick:
//   - if refractory: clears v, counts the refractory counter down, no spike
//   - otherwise: v + i - (v >> leak_shift), saturated to V_WIDTH bits, then
//     fires (spike, v=0, reload refractory, bump counter) when >= threshold
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : global enable; low freezes prescaler, step detect, neurons
//   step         : manual tick request (rising edge)
//   i_in         : packed per-neuron unsigned currents, neuron n at [n*I_WIDTH +: I_WIDTH]
//   threshold    : shared firing threshold
//   leak_shift   : leak = v >> leak_shift; 0 disables the leak
//   refrac_len   : refractory ticks after a spike
//   clr_cnt      : synchronous clear of every spike counter (beats an increment)
//   sel          : readout select for v_out / cnt_out
//   spike        : one-clk spike pulse per neuron
//   v_out        : registered membrane potential of neuron sel
//   cnt_out      : registered spike count of neuron sel
//   tick_out     : one-clk pulse per tick, one cycle after the tick cycle
// -----------------------------------------------------------------------------
module lif_neuron_array #(
    parameter int          NUM_NEURONS = 4,
    parameter int          V_WIDTH     = 8,
    parameter int          I_WIDTH     = 4,
    parameter logic [23:0] TICK_DIV    = 24'd10_000_000,
    parameter int          CNT_WIDTH   = 8,
    localparam int         SEL_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           step,
    input  logic [NUM_NEURONS*I_WIDTH-1:0] i_in,
    input  logic [V_WIDTH-1:0]             threshold,
    input  logic [2:0]                     leak_shift,
    input  logic [3:0]                     refrac_len,
    input  logic                           clr_cnt,
    input  logic [SEL_W-1:0]               sel,
    output logic [NUM_NEURONS-1:0]         spike,
    output logic [V_WIDTH-1:0]             v_out,
    output logic [CNT_WIDTH-1:0]           cnt_out,
    output logic                           tick_out
);

    localparam logic [V_WIDTH-1:0]   V_MAX   = {V_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [23:0]          presc_r;
    logic                 step_q_r;
    logic                 tick_int_s;
    logic                 step_rise_s;
    logic                 tick_s;

    logic [V_WIDTH-1:0]   v_r       [NUM_NEURONS];
    logic [3:0]           r_r       [NUM_NEURONS];
    logic [CNT_WIDTH-1:0] cnt_r     [NUM_NEURONS];

    logic [V_WIDTH-1:0]   leak_s    [NUM_NEURONS];
    logic [V_WIDTH:0]     sum_s     [NUM_NEURONS];
    logic [V_WIDTH-1:0]   sat_s     [NUM_NEURONS];
    logic [V_WIDTH-1:0]   v_nxt_s   [NUM_NEURONS];
    logic [3:0]           r_nxt_s   [NUM_NEURONS];
    logic [CNT_WIDTH-1:0] cnt_nxt_s [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] fire_s;

    // Tick generation: prescaler wrap and step rising edge merge into one tick.
    always_comb begin
        tick_int_s  = 1'b0;
        if (TICK_DIV != 24'd0) begin
            tick_int_s = (presc_r == (TICK_DIV - 24'd1));
        end else begin
            tick_int_s = 1'b0;
        end
        step_rise_s = step & ~step_q_r;
        tick_s      = ena & (tick_int_s | step_rise_s);
    end

    // Prescaler counts 0..TICK_DIV-1 while enabled, holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= 24'd0;
        end else if (ena && (TICK_DIV != 24'd0)) begin
            if (tick_int_s) begin
                presc_r <= 24'd0;
            end else begin
                presc_r <= presc_r + 24'd1;
            end
        end
    end

    // Step edge-detect register, frozen while disabled so a held step
    // cannot produce a tick when ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q_r <= 1'b0;
        end else if (ena) begin
            step_q_r <= step;
        end
    end

    // Per-neuron next-state: refractory countdown, leak/integrate/saturate, fire.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            leak_s[n]    = (leak_shift == 3'd0) ? {V_WIDTH{1'b0}} : (v_r[n] >> leak_shift);
            // leak <= v, so the subtraction cannot wrap below zero
            sum_s[n]     = {1'b0, v_r[n]} - {1'b0, leak_s[n]}
                         + {{(V_WIDTH + 1 - I_WIDTH){1'b0}}, i_in[n*I_WIDTH +: I_WIDTH]};
            sat_s[n]     = sum_s[n][V_WIDTH] ? V_MAX : sum_s[n][V_WIDTH-1:0];
            v_nxt_s[n]   = v_r[n];
            r_nxt_s[n]   = r_r[n];
            cnt_nxt_s[n] = cnt_r[n];
            fire_s[n]    = 1'b0;

            if (tick_s) begin
                if (r_r[n] != 4'd0) begin
                    v_nxt_s[n] = {V_WIDTH{1'b0}};
                    r_nxt_s[n] = r_r[n] - 4'd1;
                end else if (sat_s[n] >= threshold) begin
                    fire_s[n]  = 1'b1;
                    v_nxt_s[n] = {V_WIDTH{1'b0}};
                    r_nxt_s[n] = refrac_len;
                end else begin
                    v_nxt_s[n] = sat_s[n];
                end
            end else begin
                fire_s[n] = 1'b0;
            end

            // Clear takes priority over a same-cycle increment.
            if (clr_cnt) begin
                cnt_nxt_s[n] = {CNT_WIDTH{1'b0}};
            end else if (fire_s[n] && (cnt_r[n] != CNT_MAX)) begin
                cnt_nxt_s[n] = cnt_r[n] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_nxt_s[n] = cnt_r[n];
            end
        end
    end

    // Neuron state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_r[n]   <= {V_WIDTH{1'b0}};
                r_r[n]   <= 4'd0;
                cnt_r[n] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_r[n]   <= v_nxt_s[n];
                r_r[n]   <= r_nxt_s[n];
                cnt_r[n] <= cnt_nxt_s[n];
            end
        end
    end

    // Registered outputs: spike pulses, tick pulse and the selected readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike    <= {NUM_NEURONS{1'b0}};
            tick_out <= 1'b0;
            v_out    <= {V_WIDTH{1'b0}};
            cnt_out  <= {CNT_WIDTH{1'b0}};
        end else begin
            spike    <= fire_s;
            tick_out <= tick_s;
            if (32'(sel) < NUM_NEURONS) begin
                v_out   <= v_r[sel];
                cnt_out <= cnt_r[sel];
            end else begin
                v_out   <= {V_WIDTH{1'b0}};
                cnt_out <= {CNT_WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_array
//
// Directed bench for lif_neuron_array. The main instance has the internal
// tick disabled and is driven tick by tick through step pulses; a behavioural
// model predicts spikes and the selected readout, and each prediction is
// queued when the tick is driven and popped when the outputs appear. A second
// instance with TICK_DIV=4 covers prescaler restart, step/wrap coincidence
// and the enable freeze.
// -----------------------------------------------------------------------------
module tb_lif_neuron_array;

    localparam int NN = 4;

    logic        clk = 1'b0;
    logic        rst_n, ena, step, clr_cnt, ena4, step4;
    logic [15:0] i_in;
    logic [7:0]  threshold;
    logic [2:0]  leak_shift;
    logic [3:0]  refrac_len;
    logic [1:0]  sel;

    logic [3:0]  spike, spike4;
    logic [7:0]  v_out, v_out4, cnt_out, cnt_out4;
    logic        tick_out, tick_out4;

    typedef struct {
        logic [3:0] spk;
        logic [7:0] v;
        logic [7:0] cnt;
    } exp_t;

    exp_t        sb_q [$];
    int          mv [NN];
    int          mr [NN];
    int          mc [NN];
    int          tests_run = 0;
    int          fails     = 0;
    logic [3:0]  obs_spk;
    logic [7:0]  obs_v, obs_cnt;

    always #5 clk = ~clk;

    lif_neuron_array #(
        .NUM_NEURONS(4), .V_WIDTH(8), .I_WIDTH(4), .TICK_DIV(24'd0), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .i_in(i_in),
        .threshold(threshold), .leak_shift(leak_shift), .refrac_len(refrac_len),
        .clr_cnt(clr_cnt), .sel(sel), .spike(spike), .v_out(v_out),
        .cnt_out(cnt_out), .tick_out(tick_out)
    );

    lif_neuron_array #(
        .NUM_NEURONS(4), .V_WIDTH(8), .I_WIDTH(4), .TICK_DIV(24'd4), .CNT_WIDTH(8)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .step(step4), .i_in(i_in),
        .threshold(threshold), .leak_shift(leak_shift), .refrac_len(refrac_len),
        .clr_cnt(clr_cnt), .sel(sel), .spike(spike4), .v_out(v_out4),
        .cnt_out(cnt_out4), .tick_out(tick_out4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < NN; n++) begin
            mv[n] = 0;
            mr[n] = 0;
            mc[n] = 0;
        end
        sb_q.delete();
    endtask

    // Reference LIF update for one tick using the currently driven inputs.
    task automatic model_tick(input bit clr);
        logic [3:0] spk;
        int         leak, s, iv;
        spk = 4'd0;
        for (int n = 0; n < NN; n++) begin
            iv = int'(i_in[n*4 +: 4]);
            if (mr[n] != 0) begin
                mv[n] = 0;
                mr[n] = mr[n] - 1;
            end else begin
                leak = (leak_shift == 3'd0) ? 0 : (mv[n] >> leak_shift);
                s    = mv[n] - leak + iv;
                if (s > 255) s = 255;
                if (s >= int'(threshold)) begin
                    spk[n] = 1'b1;
                    mv[n]  = 0;
                    mr[n]  = int'(refrac_len);
                    if (mc[n] < 255) mc[n] = mc[n] + 1;
                end else begin
                    mv[n] = s;
                end
            end
        end
        if (clr) begin
            for (int n = 0; n < NN; n++) mc[n] = 0;
        end
        sb_q.push_back('{spk, 8'(mv[sel]), 8'(mc[sel])});
    endtask

    // One step-driven tick; spike/tick_out checked one edge later,
    // readout checked on the edge after that.
    task automatic do_tick(input bit clr);
        exp_t e;
        @(negedge clk);
        step    = 1'b1;
        clr_cnt = clr;
        model_tick(clr);
        @(negedge clk);
        step    = 1'b0;
        clr_cnt = 1'b0;
        e       = sb_q.pop_front();
        obs_spk = spike;
        chk("spike", 32'(spike), 32'(e.spk));
        chk("tick_out", 32'(tick_out), 32'd1);
        @(negedge clk);
        chk("spike_one_clk", 32'(spike), 32'd0);
        chk("v_out", 32'(v_out), 32'(e.v));
        chk("cnt_out", 32'(cnt_out), 32'(e.cnt));
        obs_v   = v_out;
        obs_cnt = cnt_out;
    endtask

    task automatic read_cnt(input logic [1:0] k, input logic [7:0] exp, input string tag);
        @(negedge clk);
        sel = k;
        @(negedge clk);
        chk(tag, 32'(cnt_out), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; step = 1'b0; clr_cnt = 1'b0;
        ena4 = 1'b0; step4 = 1'b0; i_in = 16'd0; threshold = 8'd20;
        leak_shift = 3'd0; refrac_len = 4'd0; sel = 2'd0;
        model_clear();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_spike", 32'(spike), 32'd0);
        chk("rst_v_out", 32'(v_out), 32'd0);
        chk("rst_cnt_out", 32'(cnt_out), 32'd0);
        chk("rst_tick_out", 32'(tick_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_tick", 32'(tick_out), 32'd0);

        // integrate and fire
        i_in = {4'd0, 4'd0, 4'd0, 4'd7};
        do_tick(1'b0);
        chk("if_v7", 32'(obs_v), 32'd7);
        do_tick(1'b0);
        chk("if_v14", 32'(obs_v), 32'd14);
        do_tick(1'b0);
        chk("if_spike", 32'(obs_spk), 32'd1);
        chk("if_v0", 32'(obs_v), 32'd0);
        chk("if_cnt1", 32'(obs_cnt), 32'd1);

        // leak settles at 8
        leak_shift = 3'd1; threshold = 8'd255; i_in = {4'd0, 4'd0, 4'd0, 4'd4};
        repeat (5) do_tick(1'b0);
        chk("leak_v8", 32'(obs_v), 32'd8);

        // saturation at 255 fires against threshold 255
        leak_shift = 3'd0; i_in = {4'd0, 4'd0, 4'd0, 4'd15};
        repeat (16) do_tick(1'b0);
        chk("sat_v248", 32'(obs_v), 32'd248);
        do_tick(1'b0);
        chk("sat_spike", 32'(obs_spk), 32'd1);
        chk("sat_v0", 32'(obs_v), 32'd0);
        chk("sat_cnt2", 32'(obs_cnt), 32'd2);

        // refractory period, with an enable freeze in the middle
        threshold = 8'd1; refrac_len = 4'd2; i_in = {4'd0, 4'd0, 4'd0, 4'd1};
        do_tick(1'b0);
        chk("ref_spike1", 32'(obs_spk), 32'd1);
        do_tick(1'b0);
        chk("ref_quiet1", 32'(obs_spk), 32'd0);
        @(negedge clk);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ena0_no_tick", 32'(tick_out), 32'd0);
            step = (k % 2 == 0) ? 1'b1 : 1'b0;
        end
        step = 1'b0;
        chk("ena0_cnt_held", 32'(cnt_out), 32'd3);
        ena = 1'b1;
        do_tick(1'b0);
        chk("ref_quiet2", 32'(obs_spk), 32'd0);
        chk("ref_v0", 32'(obs_v), 32'd0);

        // third tick after the spike fires again; reset lands while it is high
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("ref_spike2", 32'(spike), 32'd1);
        chk("ref_cnt_before_upd", 32'(cnt_out), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_spike", 32'(spike), 32'd0);
        chk("midrst_tick_out", 32'(tick_out), 32'd0);
        chk("midrst_cnt_out", 32'(cnt_out), 32'd0);
        chk("midrst_v_out", 32'(v_out), 32'd0);
        model_clear();

        // prescaler restarts from 0; coincident step gives one tick; enable hold
        @(negedge clk);
        ena4  = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("presc_tick", 32'(tick_out4), (k % 4 == 3) ? 32'd1 : 32'd0);
            step4 = (k == 6) ? 1'b1 : 1'b0;
        end
        ena4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("presc_ena0", 32'(tick_out4), 32'd0);
        end
        ena4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("presc_resume", 32'(tick_out4), (k == 3) ? 32'd1 : 32'd0);
        end
        ena4 = 1'b0;

        // channel independence
        threshold = 8'd15; refrac_len = 4'd0; leak_shift = 3'd0;
        i_in = {4'd15, 4'd0, 4'd3, 4'd8};
        repeat (4) do_tick(1'b0);
        read_cnt(2'd0, 8'd2, "chan_cnt0");
        read_cnt(2'd1, 8'd0, "chan_cnt1");
        read_cnt(2'd2, 8'd0, "chan_cnt2");
        read_cnt(2'd3, 8'd4, "chan_cnt3");

        // threshold 0: every non-refractory neuron fires
        threshold = 8'd0; i_in = 16'd0;
        do_tick(1'b0);
        chk("thr0_all_fire", 32'(obs_spk), 32'hF);
        chk("thr0_cnt3", 32'(obs_cnt), 32'd5);

        // clr_cnt coincident with spikes: clear wins
        do_tick(1'b1);
        chk("clr_spike", 32'(obs_spk), 32'hF);
        chk("clr_cnt_zero", 32'(obs_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Parametrised multi-channel leaky integrate-and-fire block.
- Holds NUM_NEURONS independent membrane potentials, each updated once per simulation tick.
- Each neuron has a configurable threshold, a shift-based leak, a refractory period and a saturating spike counter.
- Replaces the single-neuron core inside the tile top level; feeds spike pins and a selectable membrane readout.

Parameters:
- NUM_NEURONS, 4, number of neurons; sets the select-port width.
- V_WIDTH, 8, membrane potential and threshold width.
- I_WIDTH, 4, per-neuron input current width (unsigned).
- TICK_DIV, 24'd10_000_000, clk cycles per internal tick; 0 disables the internal tick.
- CNT_WIDTH, 8, per-neuron spike counter width.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: global enable; low freezes the prescaler and all neuron state.
- step, input, 1: manual tick request; its rising edge produces one tick.
- i_in, input, NUM_NEURONS*I_WIDTH: packed currents; neuron n uses bits [n*I_WIDTH +: I_WIDTH].
- threshold, input, V_WIDTH: firing threshold shared by all neurons.
- leak_shift, input, 3: leak amount is v>>leak_shift; value 0 means no leak.
- refrac_len, input, 4: number of refractory ticks after a spike.
- clr_cnt, input, 1: synchronous clear of all spike counters.
- sel, input, $clog2(NUM_NEURONS): readout select (use width 1 when NUM_NEURONS=1).
- spike, output, NUM_NEURONS: one-clk spike pulse per neuron.
- v_out, output, V_WIDTH: registered membrane potential of neuron sel.
- cnt_out, output, CNT_WIDTH: registered spike count of neuron sel.
- tick_out, output, 1: one-clk pulse on every tick, for debug.

Behaviour:
- Reset (async, rst_n=0) clears all of the following to 0:
  - prescaler, step edge-detect register
  - every v[n], refractory counter r[n], cnt[n]
  - spike, v_out, cnt_out, tick_out
- Prescaler (TICK_DIV>0):
  - counts 0..TICK_DIV-1 while ena=1 and holds while ena=0.
  - Wrap produces tick_int=1 for one cycle.
- Step detect:
  - step registered each cycle (only while ena=1).
  - step_rise = step & ~step_q.
- Tick:
  - tick = ena & (tick_int | step_rise).
  - A coincident tick_int and step_rise give a single tick, not two.
  - tick_out is tick registered, so it is one cycle late.
- Per-neuron update happens only on a tick cycle. Inputs are sampled that cycle.
  - Refractory (r[n]!=0): v[n]<=0, r[n]<=r[n]-1, no integration, no spike.
  - Otherwise:
    - leak = (leak_shift==0) ? 0 : v[n]>>leak_shift.
    - sum = v[n]-leak+i[n], computed at V_WIDTH+1 bits; it never underflows.
    - sum saturates at 2^V_WIDTH-1.
  - If sat_sum >= threshold:
    - spike[n]<=1 for exactly one clk.
    - v[n]<=0, r[n]<=refrac_len.
    - cnt[n] increments, saturating at 2^CNT_WIDTH-1.
  - Else v[n]<=sat_sum.
- Non-tick cycles: spike<=0, all state held.
- Boundary cases:
  - threshold=0: every non-refractory tick fires.
  - refrac_len=0: the neuron integrates on the very next tick.
- Latency:
  - spike asserts on the clk edge after the tick cycle.
  - v_out and cnt_out reflect post-update values one cycle after that edge, and follow a sel change with one-cycle latency.
- clr_cnt:
  - Clears all cnt[n] on the next edge.
  - Wins over a simultaneous increment; the result is 0.
- ena=0 during a refractory period: r[n] and v[n] freeze, and resume when ena returns high.
- Reset mid-operation: immediate clear; no spike pulse is emitted.
- Config changes to threshold, leak_shift and refrac_len take effect on the next tick.

Test Plan:
- Reset check: rst_n low mid-run -> all outputs 0 asynchronously; prescaler restarts from 0 after release.
- Integrate and fire: TICK_DIV=0, leak_shift=0, threshold=20, i0=7, 3 step pulses.
  - v_out(sel=0) reads 7, then 14.
  - 3rd step: spike[0] high for 1 clk, v=0, cnt_out=1.
- Leak and saturation:
  - leak_shift=1, i=4 settles at v=8 (8-4+4) with no spike when threshold=255.
  - i=15, leak_shift=0 saturates v at 255, then fires since 255>=255.
- Refractory: refrac_len=2, threshold=1, i=1.
  - Spike, then 2 ticks with v=0 and no spike, then spike again on the 3rd tick.
  - The spike period is 3 ticks.
- Channel independence: i_in={15,0,3,8}, threshold=15, 4 ticks.
  - cnt = {4,0,0,2} for neurons {3,2,1,0}, read via sel.
- Simultaneous events:
  - Coincident step rise and prescaler wrap (TICK_DIV=4) -> single tick.
  - clr_cnt coincident with a spike -> cnt=0.
  - ena=0 for 10 cycles -> no tick_out and state unchanged.
